// File: rtl/frame_packer_pkg.sv
// Shared constants and framer state type for the frame_packer slice.
package frame_packer_pkg;

  localparam logic [7:0] HDR0_BYTE = 8'hAA;
  localparam logic [7:0] HDR1_BYTE = 8'h55;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_LEN,
    ST_PAY,
    ST_CHK,
    ST_GAP
  } state_t;

endpackage

// File: rtl/frame_packer_payload_fifo.sv
// Payload byte FIFO, first-word-fall-through: dout always shows the head entry.
module payload_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [CW-1:0] r_cnt;
  logic          w_do_push;
  logic          w_do_pop;

  assign full      = (r_cnt == CW'(DEPTH));
  assign empty     = (r_cnt == '0);
  assign count     = r_cnt;
  assign dout      = r_mem[r_rd];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + AW'(1);
      if (w_do_pop)  r_rd <= r_rd + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/frame_packer.sv
// Packetiser: buffers payload bytes and emits AA 55 LEN payload CHK as paced byte strobes.
module frame_packer
  import frame_packer_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int BYTE_GAP = 544
) (
  input  logic       CLOCK_50M,
  input  logic       RST_n,
  input  logic       Wr_En,
  input  logic [7:0] Wr_Data,
  output logic       Wr_Ready,
  input  logic       Send_Req,
  output logic       Busy,
  output logic       Done,
  output logic       Frame_Start_Sig,
  output logic       Data_Send_Sig,
  output logic [7:0] Data
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int GW = $clog2(BYTE_GAP);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [GW-1:0] r_gap;
  logic [CW-1:0] r_len;
  logic [CW-1:0] r_left;
  logic [7:0]    r_sum;
  logic [7:0]    r_data;
  logic          r_busy;
  logic          r_done;
  logic          r_strobe;
  logic          r_fs;

  logic          w_push;
  logic          w_pop;
  logic [7:0]    w_dout;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_len_now;
  logic          w_full;
  logic          w_empty;
  logic          w_fire;
  logic          w_done;
  logic [7:0]    w_byte;

  assign Wr_Ready        = !r_busy && !w_full;
  assign w_push          = Wr_En && Wr_Ready;
  assign w_len_now       = w_count + CW'(w_push);
  assign Busy            = r_busy;
  assign Done            = r_done;
  assign Frame_Start_Sig = r_fs;
  assign Data_Send_Sig   = r_strobe;
  assign Data            = r_data;

  payload_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (CLOCK_50M),
    .rst_n (RST_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   (Wr_Data),
    .dout  (w_dout),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge CLOCK_50M or negedge RST_n) begin
    if (!RST_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // A byte state fires once its gap count has expired; strobes are registered,
  // so the HDR0 byte appears one edge after the request is accepted.
  always_comb begin
    w_state_nxt = r_state;
    w_byte      = '0;
    w_pop       = 1'b0;
    w_done      = 1'b0;
    w_fire      = (r_state inside {ST_HDR0, ST_HDR1, ST_LEN, ST_PAY, ST_CHK}) && (r_gap == '0);
    case (r_state)
      ST_IDLE: if (Send_Req && (!w_empty || w_push)) w_state_nxt = ST_HDR0;
      ST_HDR0: begin
        w_byte = HDR0_BYTE;
        if (w_fire) w_state_nxt = ST_HDR1;
      end
      ST_HDR1: begin
        w_byte = HDR1_BYTE;
        if (w_fire) w_state_nxt = ST_LEN;
      end
      ST_LEN: begin
        w_byte = 8'(r_len);
        if (w_fire) w_state_nxt = ST_PAY;
      end
      ST_PAY: begin
        w_byte = w_dout;
        w_pop  = w_fire;
        if (w_fire && r_left == CW'(1)) w_state_nxt = ST_CHK;
      end
      ST_CHK: begin
        w_byte = r_sum;
        if (w_fire) w_state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (r_gap == '0) begin
          w_state_nxt = ST_IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // LEN is latched at the HDR0 strobe so a write landing in the launch cycle is still counted.
  always_ff @(posedge CLOCK_50M or negedge RST_n) begin
    if (!RST_n) begin
      r_gap    <= '0;
      r_len    <= '0;
      r_left   <= '0;
      r_sum    <= '0;
      r_data   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_strobe <= 1'b0;
      r_fs     <= 1'b0;
    end else begin
      r_strobe <= w_fire;
      r_fs     <= w_fire && (r_state == ST_HDR0);
      r_done   <= w_done;
      if (w_fire) begin
        r_data <= w_byte;
        r_gap  <= GW'(BYTE_GAP - 1);
      end else if (r_gap != '0) begin
        r_gap <= r_gap - GW'(1);
      end
      if (w_fire && r_state == ST_HDR0) begin
        r_busy <= 1'b1;
        r_len  <= w_len_now;
        r_sum  <= 8'(w_len_now);
      end
      if (w_done) r_busy <= 1'b0;
      if (w_fire && r_state == ST_LEN) r_left <= r_len;
      if (w_pop) begin
        r_left <= r_left - CW'(1);
        r_sum  <= r_sum + w_dout;
      end
    end
  end

endmodule
